vga_timing_gen: RTL and testbench

//  Source end of the pixel-scan interface: generates DrawX/DrawY/blank consumed by the

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/sync_delay_line.sv | 37 +++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 scan timing constants and coordinate type for the pixel-scan interface.
// Latency: n/a (constants only).
// Backpressure: n/a; the scan source is free-running and never stalls.
package vga_timing_pkg;

    // Default 640x480 timing, in pixel clocks (horizontal) and lines (vertical)
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are half-open: START <= count < END
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam bit SYNC_POL = 1'b0;
    localparam int PIPE_DLY = 1;
    localparam int FRAME_W  = 16;

    typedef logic [9:0] scan_coord_t;

    // Narrow an integer timing constant to the 10-bit scan coordinate width
    function automatic scan_coord_t to_coord(input int v);
        return scan_coord_t'(v);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Shift register that delays the raw sync levels so they line up with registered RGB.
// Latency: DEPTH clocks from dat_i to dat_o (DEPTH >= 1).
// Backpressure: none; shifts every clock, reset loads every stage with INIT.
module sync_delay_line
    import vga_timing_pkg::*;
#(
    parameter int               WIDTH = 2,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("sync_delay_line: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift the sync levels one stage per clock; reset fills the line with the idle level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= {DEPTH{INIT}};
        end else begin
            stage_q[0] <= dat_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dat_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-scan source: DrawX/DrawY/blank, delayed hs/vs, line/frame pulses and a frame counter.
// Latency: DrawX/DrawY/blank/pulses zero-latency from the counters; hs/vs lag by PIPE_DLY clocks.
// Backpressure: none; free-running once the first edge after reset release sets run.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL,
    parameter int PIPE_DLY = vga_timing_pkg::PIPE_DLY,
    parameter int FRAME_W  = vga_timing_pkg::FRAME_W
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    output logic [9:0]         DrawX,
    output logic [9:0]         DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    import vga_timing_pkg::*;

    localparam int H_TOTAL_C = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_C = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL_C > 1024 || V_TOTAL_C > 1024) begin : g_bad_timing
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit the 10-bit scan counters");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE_DLY must be in 0..4");
    end

    localparam scan_coord_t H_LAST   = to_coord(H_TOTAL_C - 1);
    localparam scan_coord_t V_LAST   = to_coord(V_TOTAL_C - 1);
    localparam scan_coord_t H_ACT_C  = to_coord(H_ACTIVE);
    localparam scan_coord_t V_ACT_C  = to_coord(V_ACTIVE);
    localparam scan_coord_t HS_BEG_C = to_coord(H_ACTIVE + H_FP);
    localparam scan_coord_t HS_END_C = to_coord(H_ACTIVE + H_FP + H_SYNC);
    localparam scan_coord_t VS_BEG_C = to_coord(V_ACTIVE + V_FP);
    localparam scan_coord_t VS_END_C = to_coord(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [FRAME_W-1:0] FC_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};
    localparam logic               IDLE_LVL = ~SYNC_POL;

    scan_coord_t        hc_q, hc_d;
    scan_coord_t        vc_q, vc_d;
    logic               run_q;
    logic [FRAME_W-1:0] fc_q, fc_d;

    logic hs_raw;
    logic vs_raw;
    logic [1:0] sync_lvl;

    // Raster advance: step across the line, wrap into the next line, and count a
    // completed frame on the edge that returns the scan to (0,0)
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        fc_d = fc_q;
        if (run_q) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d = '0;
                    fc_d = fc_q + FC_ONE;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Scan state; run rises on the first edge after release so frame 0 starts at (0,0)
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            hc_q  <= '0;
            vc_q  <= '0;
            fc_q  <= '0;
        end else begin
            run_q <= 1'b1;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            fc_q  <= fc_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign frame_count = fc_q;
    assign blank       = run_q & (hc_q < H_ACT_C) & (vc_q < V_ACT_C);
    assign line_start  = run_q & (hc_q == '0);
    assign frame_start = line_start & (vc_q == '0);

    // vs_raw looks at the line count only, so it toggles together with the hc wrap
    assign hs_raw   = (hc_q >= HS_BEG_C) && (hc_q < HS_END_C);
    assign vs_raw   = (vc_q >= VS_BEG_C) && (vc_q < VS_END_C);
    assign sync_lvl = {hs_raw ? SYNC_POL : IDLE_LVL, vs_raw ? SYNC_POL : IDLE_LVL};

    if (PIPE_DLY == 0) begin : g_sync_direct
        assign {hs, vs} = sync_lvl;
    end else begin : g_sync_delayed
        sync_delay_line #(
            .WIDTH (2),
            .DEPTH (PIPE_DLY),
            .INIT  ({IDLE_LVL, IDLE_LVL})
        ) u_sync_dly (
            .clk_i  (vga_clk),
            .rst_ni (reset_n),
            .dat_i  (sync_lvl),
            .dat_o  ({hs, vs})
        );
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every clock against a raster model.
// Model derives every output from the number of edges since reset release.
// Resets are applied mid-cycle at targeted and random points in the scan.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic vga_clk;
    logic reset_n;

    // d0: default 640x480, PIPE_DLY=1, active-low sync
    logic [9:0]  x0, y0;
    logic        bl0, hs0, vs0, ls0, fs0;
    logic [15:0] fc0;
    // d1: small raster, FRAME_W=2, PIPE_DLY=1, active-low sync
    logic [9:0]  x1, y1;
    logic        bl1, hs1, vs1, ls1, fs1;
    logic [1:0]  fc1;
    // d2: small raster, PIPE_DLY=0, active-high sync
    logic [9:0]  x2, y2;
    logic        bl2, hs2, vs2, ls2, fs2;
    logic [15:0] fc2;

    int t;          // edges since the run flag was set; -1 while not running
    int n_checks;
    int n_errors;

    vga_timing_gen u_d0 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x0), .DrawY(y0), .blank(bl0),
        .hs(hs0), .vs(vs0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .PIPE_DLY(1), .FRAME_W(2)
    ) u_d1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x1), .DrawY(y1), .blank(bl1),
        .hs(hs1), .vs(vs1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .PIPE_DLY(0), .FRAME_W(16)
    ) u_d2 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(x2), .DrawY(y2), .blank(bl2),
        .hs(hs2), .vs(vs2), .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // Expected outputs for a raster that has been running for tt edges (tt<0: idle)
    function automatic exp_t model(input int tt,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit pol, input int dly, input int fw);
        exp_t e;
        int ht, vt, td, xd, yd, px, py;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        e.x = '0; e.y = '0; e.blank = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.fc = '0;
        e.hs = ~pol; e.vs = ~pol;
        if (tt >= 0) begin
            px      = tt % ht;
            py      = (tt / ht) % vt;
            e.x     = 10'(px);
            e.y     = 10'(py);
            e.fc    = 16'((tt / (ht * vt)) % (1 << fw));
            e.blank = (px < ha) && (py < va);
            e.ls    = (px == 0);
            e.fs    = (px == 0) && (py == 0);
            td = tt - dly;
            if (td >= 0) begin
                xd = td % ht;
                yd = (td / ht) % vt;
                e.hs = ((xd >= ha + hf) && (xd < ha + hf + hsw)) ? pol : ~pol;
                e.vs = ((yd >= va + vf) && (yd < va + vf + vsw)) ? pol : ~pol;
            end
        end
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
        end
    endtask

    task automatic cmp_inst(input string nm, input exp_t e,
                            input logic [9:0] x, input logic [9:0] y, input logic bl,
                            input logic h, input logic v, input logic ls, input logic fs,
                            input logic [15:0] fc);
        check_eq({nm, ".DrawX"},       32'(x),  32'(e.x));
        check_eq({nm, ".DrawY"},       32'(y),  32'(e.y));
        check_eq({nm, ".blank"},       32'(bl), 32'(e.blank));
        check_eq({nm, ".hs"},          32'(h),  32'(e.hs));
        check_eq({nm, ".vs"},          32'(v),  32'(e.vs));
        check_eq({nm, ".line_start"},  32'(ls), 32'(e.ls));
        check_eq({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
        check_eq({nm, ".frame_count"}, 32'(fc), 32'(e.fc));
    endtask

    task automatic check_all();
        exp_t e;
        e = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1, 16);
        cmp_inst("d0", e, x0, y0, bl0, hs0, vs0, ls0, fs0, fc0);
        e = model(t, 8, 2, 3, 3, 4, 1, 2, 2, 1'b0, 1, 2);
        cmp_inst("d1", e, x1, y1, bl1, hs1, vs1, ls1, fs1, {14'b0, fc1});
        e = model(t, 8, 2, 3, 3, 4, 1, 2, 2, 1'b1, 0, 16);
        cmp_inst("d2", e, x2, y2, bl2, hs2, vs2, ls2, fs2, fc2);
    endtask

    // Advance n clocks, checking every output on each falling edge
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            if (reset_n) t++;
            @(negedge vga_clk);
            check_all();
        end
    endtask

    // Drop reset between edges, check it took effect with no clock, hold, then release
    task automatic mid_cycle_reset(input int hold);
        #2 reset_n = 1'b0;
        t = -1;
        #1 check_all();
        @(negedge vga_clk);
        repeat (hold) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            check_all();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        t        = -1;
        reset_n  = 1'b0;

        repeat (3) begin
            @(negedge vga_clk);
            check_all();
        end
        reset_n = 1'b1;

        // First line and a bit: lands d0 on DrawX=300, DrawY=1 before the reset
        run_cycles(1101);
        mid_cycle_reset(2);

        // Full startup again, two-plus lines of d0 and many frames of the small rasters
        run_cycles(2000);

        // Resets dropped at random scan positions with random hold times
        for (int k = 0; k < 3; k++) begin
            run_cycles($urandom_range(1500, 50));
            mid_cycle_reset($urandom_range(4, 1));
        end
        run_cycles(600);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
